// File: rtl/nes_clk_en_gen.sv
// Parametrised clock-enable generator for the CPU, PPU and VGA domains.
// Produces one-cycle enable strobes, the M2 bus phase and a stretched CPU
// reset, all from the single master clock. Every output is a flop.
// Optional single-step debug support is enabled by NES_CLKGEN_STEP_EN.
module nes_clk_en_gen #(
  parameter int unsigned CPU_DIV   = 12,
  parameter int unsigned PPU_DIV   = 4,
  parameter int unsigned VGA_DIV   = 2,
  parameter int unsigned PPU_PHASE = 0,
  parameter int unsigned M2_LOW    = 5,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cpu_halt_i,
  input  logic cpu_step_i,
  output logic cpu_ce_o,
  output logic ppu_ce_o,
  output logic vga_ce_o,
  output logic m2_o,
  output logic rst_cpu_o,
  output logic cpu_halted_o
);

  localparam int unsigned CpuW  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int unsigned PpuW  = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;
  localparam int unsigned VgaW  = (VGA_DIV > 1) ? $clog2(VGA_DIV) : 1;
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  localparam logic [CpuW-1:0]  CpuLast  = CpuW'(CPU_DIV - 1);
  localparam logic [CpuW-1:0]  M2Low    = CpuW'(M2_LOW);
  localparam logic [PpuW-1:0]  PpuLast  = PpuW'(PPU_DIV - 1);
  localparam logic [PpuW-1:0]  PpuPhase = PpuW'(PPU_PHASE);
  localparam logic [VgaW-1:0]  VgaLast  = VgaW'(VGA_DIV - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  // Reject illegal parameter sets at elaboration
  if (CPU_DIV < 2) begin : gen_chk_cpu_div
    $error("nes_clk_en_gen: CPU_DIV must be >= 2");
  end
  if (PPU_DIV < 1) begin : gen_chk_ppu_div
    $error("nes_clk_en_gen: PPU_DIV must be >= 1");
  end
  if (VGA_DIV < 1) begin : gen_chk_vga_div
    $error("nes_clk_en_gen: VGA_DIV must be >= 1");
  end
  if (PPU_PHASE >= PPU_DIV) begin : gen_chk_ppu_phase
    $error("nes_clk_en_gen: PPU_PHASE must be < PPU_DIV");
  end
  if ((M2_LOW < 1) || (M2_LOW > CPU_DIV - 1)) begin : gen_chk_m2_low
    $error("nes_clk_en_gen: M2_LOW must be in 1..CPU_DIV-1");
  end
  if (RST_HOLD < 1) begin : gen_chk_rst_hold
    $error("nes_clk_en_gen: RST_HOLD must be >= 1");
  end

`ifdef NES_CLKGEN_STEP_EN
  typedef enum logic [1:0] {StRun, StHalt, StStep} state_e;
`else
  typedef enum logic [0:0] {StRun, StHalt} state_e;
`endif

  state_e           state_q, state_d;
  logic [CpuW-1:0]  cpu_cnt_q, cpu_cnt_d;
  logic [PpuW-1:0]  ppu_cnt_q, ppu_cnt_d;
  logic [VgaW-1:0]  vga_cnt_q, vga_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             ppu_ce_q, ppu_ce_d;
  logic             vga_ce_q, vga_ce_d;
  logic             m2_q, m2_d;
  logic             rst_cpu_q, rst_cpu_d;
  logic             halted_q, halted_d;
  logic             cpu_wrap;
  logic             running_d;

`ifdef NES_CLKGEN_STEP_EN
  logic step_q;
  logic step_rise;

  // Remember last cpu_step so only a rising edge requests a step
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q <= 1'b0;
    end else begin
      step_q <= cpu_step_i;
    end
  end

  assign step_rise = cpu_step_i & ~step_q;
`else
  logic unused_step;
  assign unused_step = cpu_step_i;
`endif

  assign cpu_wrap = (cpu_cnt_q == CpuLast);

  // Halt FSM: halting only at a CPU period boundary keeps periods whole
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (cpu_halt_i && cpu_wrap) state_d = StHalt;
      end
      StHalt: begin
        if (!cpu_halt_i) begin
          state_d = StRun;
`ifdef NES_CLKGEN_STEP_EN
        end else if (step_rise) begin
          state_d = StStep;
`endif
        end
      end
`ifdef NES_CLKGEN_STEP_EN
      StStep: begin
        if (cpu_wrap) state_d = cpu_halt_i ? StHalt : StRun;
      end
`endif
      default: state_d = StRun;
    endcase
  end

  // Counters and next output values; outputs are derived from next state
  always_comb begin
    running_d = (state_d != StHalt);

    // Leaving or entering HALT always restarts the CPU period from zero
    if ((state_q == StHalt) || (state_d == StHalt) || cpu_wrap) begin
      cpu_cnt_d = '0;
    end else begin
      cpu_cnt_d = cpu_cnt_q + 1'b1;
    end

    ppu_cnt_d = (ppu_cnt_q == PpuLast) ? '0 : ppu_cnt_q + 1'b1;
    vga_cnt_d = (vga_cnt_q == VgaLast) ? '0 : vga_cnt_q + 1'b1;

    cpu_ce_d = running_d && (cpu_cnt_d == CpuLast);
    m2_d     = running_d && (cpu_cnt_d >= M2Low);
    halted_d = (state_d == StHalt);
    ppu_ce_d = (ppu_cnt_d == PpuLast);
    vga_ce_d = (vga_cnt_d == VgaLast);

    // Count CPU strobes while the CPU reset is held
    hold_d    = hold_q;
    rst_cpu_d = rst_cpu_q;
    if (rst_cpu_q && cpu_ce_q) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HoldLast) rst_cpu_d = 1'b0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StRun;
      cpu_cnt_q <= '0;
      ppu_cnt_q <= PpuPhase;
      vga_cnt_q <= '0;
      hold_q    <= '0;
      cpu_ce_q  <= 1'b0;
      ppu_ce_q  <= 1'b0;
      vga_ce_q  <= 1'b0;
      m2_q      <= 1'b0;
      rst_cpu_q <= 1'b1;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_cnt_q <= cpu_cnt_d;
      ppu_cnt_q <= ppu_cnt_d;
      vga_cnt_q <= vga_cnt_d;
      hold_q    <= hold_d;
      cpu_ce_q  <= cpu_ce_d;
      ppu_ce_q  <= ppu_ce_d;
      vga_ce_q  <= vga_ce_d;
      m2_q      <= m2_d;
      rst_cpu_q <= rst_cpu_d;
      halted_q  <= halted_d;
    end
  end

  assign cpu_ce_o     = cpu_ce_q;
  assign ppu_ce_o     = ppu_ce_q;
  assign vga_ce_o     = vga_ce_q;
  assign m2_o         = m2_q;
  assign rst_cpu_o    = rst_cpu_q;
  assign cpu_halted_o = halted_q;

endmodule

// File: tb/tb_nes_clk_en_gen.sv
// Testbench for nes_clk_en_gen: default instance plus a PPU_PHASE=2 instance
// sharing the same stimulus. Expected output vectors are queued per cycle
// and compared against both instances.
module tb_nes_clk_en_gen;

  logic clk;
  logic reset_i;
  logic cpu_halt_i;
  logic cpu_step_i;

  logic cpu_ce, ppu_ce, vga_ce, m2, rst_cpu, cpu_halted;
  logic cpu_ce2, ppu_ce2, m2_2;
  logic unused_vga2, unused_rst2, unused_halted2;

  nes_clk_en_gen u_dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cpu_halt_i   (cpu_halt_i),
    .cpu_step_i   (cpu_step_i),
    .cpu_ce_o     (cpu_ce),
    .ppu_ce_o     (ppu_ce),
    .vga_ce_o     (vga_ce),
    .m2_o         (m2),
    .rst_cpu_o    (rst_cpu),
    .cpu_halted_o (cpu_halted)
  );

  nes_clk_en_gen #(
    .PPU_PHASE (2)
  ) u_dut_ph2 (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cpu_halt_i   (cpu_halt_i),
    .cpu_step_i   (cpu_step_i),
    .cpu_ce_o     (cpu_ce2),
    .ppu_ce_o     (ppu_ce2),
    .vga_ce_o     (unused_vga2),
    .m2_o         (m2_2),
    .rst_cpu_o    (unused_rst2),
    .cpu_halted_o (unused_halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Vector: {cpu_ce, ppu_ce, vga_ce, m2, rst_cpu, cpu_halted, ppu_ce_ph2, cpu_ce_ph2, m2_ph2}
  function automatic logic [8:0] mk(int cp, bit ce, bit m, bit rst, bit hlt);
    bit p  = ((cp % 4) == 3);
    bit v  = ((cp % 2) == 1);
    bit p2 = ((cp % 4) == 1);
    return {ce, p, v, m, rst, hlt, p2, ce, m};
  endfunction

  // Running CPU, k cycles into the current chain of periods
  function automatic logic [8:0] run_at(int cp, int k, bit rst);
    return mk(cp, (k % 12) == 11, (k % 12) >= 5, rst, 1'b0);
  endfunction

  function automatic logic [8:0] halt_at(int cp, bit rst);
    return mk(cp, 1'b0, 1'b0, rst, 1'b1);
  endfunction

  // Expected outputs for scenario scn at step i (cycle numbering from last reset)
  function automatic logic [8:0] exp_vec(int scn, int i);
    int c;
    case (scn)
      0: return run_at(i, i, i < 48);
      1: begin
        if (i <= 35) return run_at(i, i, 1'b1);
        if (i <= 60) return halt_at(i, 1'b1);
        return run_at(i, i - 61, i < 73);
      end
      2: begin
        if (i <= 23) return run_at(i, i, 1'b1);
        if (i <= 40) return halt_at(i, 1'b1);
        return run_at(i, i - 41, i < 65);
      end
      3: begin
        c = (i <= 17) ? i : i - 18;
        return run_at(c, c, c < 48);
      end
      4: begin
        if (i <= 11) return run_at(i, i, 1'b1);
        if (i <= 20) return halt_at(i, 1'b1);
        c = i - 21;
        return run_at(c, c, c < 48);
      end
      default: begin
        if (i <= 11) return run_at(i, i, 1'b1);
`ifdef NES_CLKGEN_STEP_EN
        if (i >= 21 && i <= 32) return run_at(i, i - 21, 1'b1);
`endif
        return halt_at(i, 1'b1);
      end
    endcase
  endfunction

  function automatic bit halt_of(int scn, int i);
    case (scn)
      1:       return (i >= 30 && i <= 59);
      2:       return (i >= 20 && i <= 39);
      4:       return (i <= 20);
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit step_of(int scn, int i);
    return (scn == 5) && (i >= 20 && i <= 22);
  endfunction

  function automatic bit rst_of(int scn, int i);
    return ((scn == 3) && (i == 17)) || ((scn == 4) && (i == 20));
  endfunction

  task automatic check(input string tag);
    exp_t       e;
    logic [8:0] act;
    e   = sb_q.pop_front();
    act = {cpu_ce, ppu_ce, vga_ce, m2, rst_cpu, cpu_halted, ppu_ce2, cpu_ce2, m2_2};
    n_checks++;
    assert (act === e.vec)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, e.cyc, act, e.vec);
    end
  endtask

  // Reset, then step n cycles driving inputs and checking each cycle's outputs
  task automatic run_scn(input int scn, input int n, input string tag);
    reset_i    = 1'b1;
    cpu_halt_i = 1'b0;
    cpu_step_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      cpu_halt_i = halt_of(scn, i);
      cpu_step_i = step_of(scn, i);
      reset_i    = rst_of(scn, i);
      sb_q.push_back('{i, exp_vec(scn, i)});
      check(tag);
      @(posedge clk);
      #1;
    end
    reset_i    = 1'b0;
    cpu_halt_i = 1'b0;
    cpu_step_i = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    cpu_halt_i = 1'b0;
    cpu_step_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_scn(0, 60, "free_run");
    run_scn(1, 90, "halt_30_60");
    run_scn(2, 80, "halt_in_rst_hold");
    run_scn(3, 68, "reset_at_17");
    run_scn(4, 75, "reset_while_halted");
    run_scn(5, 45, "step_pulse");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
